// File: rtl/mux_scan_serializer_if.sv
// Handshake and mux-side bundle for mux_scan_serializer.
// master = the serializer, slave = upstream/mux/downstream environment.
interface mux_scan_serializer_if #(
  parameter int N  = 16,
  parameter int SW = 4
);
  logic          load_valid;
  logic          load_ready;
  logic [N-1:0]  load_data;
  logic [N-1:0]  mux_w;
  logic [SW-1:0] mux_s;
  logic          mux_f;
  logic          ser_valid;
  logic          ser_ready;
  logic          ser_data;
  logic          ser_last;
  logic          busy;

  modport master (
    input  load_valid, load_data, mux_f, ser_ready,
    output load_ready, mux_w, mux_s, ser_valid, ser_data, ser_last, busy
  );

  modport slave (
    output load_valid, load_data, mux_f, ser_ready,
    input  load_ready, mux_w, mux_s, ser_valid, ser_data, ser_last, busy
  );
endinterface

// File: rtl/mux_scan_serializer.sv
// Sequencer for a combinational N:1 mux: holds a word, scans the selects, serializes mux_f.
// Optional trailing even-parity bit when SCAN_PARITY_EN is defined.
//
// state | meaning
// IDLE  | waiting for a word, load_ready=1
// SHIFT | offering mux_f for channel mux_s
// PAR   | offering the even-parity bit (SCAN_PARITY_EN only)
module mux_scan_serializer #(
  parameter int N         = 16,
  parameter int SW        = 4,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic clk,
  input  logic resetn,
  mux_scan_serializer_if.master bus
);

  localparam logic [SW-1:0] LAST_CNT  = SW'(N - 1);
  localparam logic [SW-1:0] FIRST_SEL = MSB_FIRST ? LAST_CNT : '0;

`ifdef SCAN_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PAR} state_t;
`else
  typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

  state_t        state, state_nxt;
  logic [N-1:0]  word_q;
  logic [SW-1:0] sel_q;
  logic [SW-1:0] cnt_q;
  logic          load_ready_c, ser_valid_c, ser_data_c, ser_last_c;
  logic          load_fire, shift_fire, last_bit;

`ifdef SCAN_PARITY_EN
  logic          parity_q;
`endif

  assign load_fire  = bus.load_valid & load_ready_c;
  assign shift_fire = (state == SHIFT) & bus.ser_ready;
  assign last_bit   = (cnt_q == LAST_CNT);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state  <= IDLE;
      word_q <= '0;
      sel_q  <= '0;
      cnt_q  <= '0;
`ifdef SCAN_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      if (load_fire) begin
        word_q <= bus.load_data;
        sel_q  <= FIRST_SEL;
        cnt_q  <= '0;
`ifdef SCAN_PARITY_EN
        parity_q <= 1'b0;
`endif
      end else if (shift_fire) begin
`ifdef SCAN_PARITY_EN
        parity_q <= parity_q ^ bus.mux_f;
`endif
        // The select never wraps: the final bit leaves SHIFT instead of stepping.
        if (!last_bit) begin
          cnt_q <= cnt_q + 1'b1;
          sel_q <= MSB_FIRST ? sel_q - 1'b1 : sel_q + 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_nxt    = state;
    load_ready_c = 1'b0;
    ser_valid_c  = 1'b0;
    ser_data_c   = 1'b0;
    ser_last_c   = 1'b0;
    case (state)
      IDLE: begin
        load_ready_c = 1'b1;
        if (bus.load_valid) state_nxt = SHIFT;
      end
      SHIFT: begin
        ser_valid_c = 1'b1;
        ser_data_c  = bus.mux_f;
`ifdef SCAN_PARITY_EN
        if (bus.ser_ready && last_bit) state_nxt = PAR;
`else
        ser_last_c = last_bit;
        if (bus.ser_ready && last_bit) state_nxt = IDLE;
`endif
      end
`ifdef SCAN_PARITY_EN
      PAR: begin
        ser_valid_c = 1'b1;
        ser_data_c  = parity_q;
        ser_last_c  = 1'b1;
        if (bus.ser_ready) state_nxt = IDLE;
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.load_ready = load_ready_c;
  assign bus.ser_valid  = ser_valid_c;
  assign bus.ser_data   = ser_data_c;
  assign bus.ser_last   = ser_last_c;
  assign bus.mux_w      = word_q;
  assign bus.mux_s      = sel_q;
  assign bus.busy       = (state != IDLE);

endmodule
